panel_switch_scanner: RTL and testbench

Front-panel switch reader for the quokka board: the input counterpart of the LED `display` serializer. Drives a chain of parallel-in/serial-out shift registers (74HC165-style) with `sclk`/`sload_n`, deserializes `sdata` into a switch vector, debounces it across whole scans, and presents a stable vector plus a one-cycle press-event vector to the front-panel control logic. Scanning runs continuously after reset.

---
 rtl/panel_pkg.sv | 28 ++
 rtl/switch_debounce.sv | 70 +++++++
 rtl/panel_switch_scanner.sv | 121 ++++++++++++
 tb/tb_panel_switch_scanner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel switch scanner and the logic that consumes
// its debounced switch vector.
`timescale 1ns/1ps
package panel_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_t;

  localparam int DEFAULT_NUM_BITS = 32;

  // Bit positions inside the debounced switch vector for the default 32-bit chain.
  typedef enum int {
    SW_DATA_LSB = 0,
    SW_DATA_MSB = 11,
    SW_ADDR_LSB = 12,
    SW_ADDR_MSB = 26,
    SW_EXAMINE  = 27,
    SW_DEPOSIT  = 28,
    SW_STEP     = 29,
    SW_HALT     = 30,
    SW_RUN      = 31
  } panel_switch_e;

endpackage

// File: rtl/switch_debounce.sv
// Whole-scan debouncer: accepts a raw scan only after DEBOUNCE_SCANS identical scans
// in a row, then publishes it with a one-cycle valid pulse and per-bit press events.
`timescale 1ns/1ps
module switch_debounce
  import panel_pkg::*;
#(
  parameter int NUM_BITS       = DEFAULT_NUM_BITS,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_commit,
  input  logic [NUM_BITS-1:0] i_raw,
  output logic [NUM_BITS-1:0] o_switches,
  output logic                o_valid,
  output logic [NUM_BITS-1:0] o_pressed
);

  localparam int              CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [NUM_BITS-1:0] r_cand;
  logic [CW-1:0]       r_count;
  logic [NUM_BITS-1:0] r_switches;
  logic [NUM_BITS-1:0] r_pressed;
  logic                r_valid;

  logic [NUM_BITS-1:0] w_cand_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic                w_accept;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_cand_nxt  = r_cand;
    w_count_nxt = r_count;
    if (i_raw == r_cand) begin
      if (r_count != CNT_MAX) w_count_nxt = r_count + 1'b1;
    end else begin
      w_cand_nxt  = i_raw;
      w_count_nxt = CNT_ONE;
    end
    w_accept = i_commit && (w_count_nxt == CNT_MAX) && (w_cand_nxt != r_switches);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand     <= '0;
      r_count    <= '0;
      r_switches <= '0;
      r_pressed  <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (i_commit) begin
        r_cand  <= w_cand_nxt;
        r_count <= w_count_nxt;
      end
      if (w_accept) r_switches <= w_cand_nxt;
      // Press events are relative to the vector being replaced, and clear after one cycle.
      r_pressed <= w_accept ? (w_cand_nxt & ~r_switches) : '0;
      r_valid   <= w_accept;
    end
  end

  assign o_switches = r_switches;
  assign o_pressed  = r_pressed;
  assign o_valid    = r_valid;

endmodule

// File: rtl/panel_switch_scanner.sv
// Front-panel switch reader: drives a 74HC165-style chain with sclk/sload_n,
// deserializes sdata per scan and hands each full scan to the debouncer.
`timescale 1ns/1ps
module panel_switch_scanner
  import panel_pkg::*;
#(
  parameter int NUM_BITS       = DEFAULT_NUM_BITS,
  parameter int CLK_DIV        = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdata,
  output logic                sclk,
  output logic                sload_n,
  output logic [NUM_BITS-1:0] switches,
  output logic                switchesValid,
  output logic [NUM_BITS-1:0] pressed
);

  localparam int            PW        = $clog2(2 * CLK_DIV);
  localparam int            BW        = $clog2(NUM_BITS);
  localparam logic [PW-1:0] HALF_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] FULL_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);

  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [PW-1:0]       r_phase;
  logic [BW-1:0]       r_bit;
  logic [1:0]          r_sync;
  logic [NUM_BITS-1:0] r_raw;
  logic                r_sclk;
  logic                r_sload_n;

  logic                w_sdata_sync;
  logic                w_sclk_nxt;
  logic                w_sload_n_nxt;
  logic                w_sample;
  logic                w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], sdata};
  end

  assign w_sdata_sync = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (r_phase == HALF_LAST) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_phase == HALF_LAST) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_phase == FULL_LAST && r_bit == BIT_LAST) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  // Phase counts cycles within a state (or within one bit period while shifting).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_bit   <= '0;
    end else if (w_state_nxt != r_state) begin
      r_phase <= '0;
      r_bit   <= '0;
    end else if (r_state == ST_SHIFT && r_phase == FULL_LAST) begin
      r_phase <= '0;
      r_bit   <= r_bit + 1'b1;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  always_comb begin
    w_sload_n_nxt = (r_state != ST_LOAD);
    w_sclk_nxt    = (r_state == ST_SHIFT) && (r_phase > HALF_LAST);
    w_sample      = (r_state == ST_SHIFT) && (r_phase == HALF_LAST);
    w_commit      = (r_state == ST_COMMIT);
  end

  // Chain controls are registered, trailing the state by one cycle; the sample point
  // still lands at the end of each low half, long after the synchronizer has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk    <= 1'b0;
      r_sload_n <= 1'b1;
    end else begin
      r_sclk    <= w_sclk_nxt;
      r_sload_n <= w_sload_n_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_raw <= '0;
    else if (w_sample) r_raw <= {r_raw[NUM_BITS-2:0], w_sdata_sync};
  end

  switch_debounce #(
    .NUM_BITS       (NUM_BITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_commit   (w_commit),
    .i_raw      (r_raw),
    .o_switches (switches),
    .o_valid    (switchesValid),
    .o_pressed  (pressed)
  );

  assign sclk    = r_sclk;
  assign sload_n = r_sload_n;

endmodule

// File: tb/tb_panel_switch_scanner.sv
// Bench for panel_switch_scanner: behavioural 74HC165 chain plus a scan-history
// reference model of the debounced vector and press events.
`timescale 1ns/1ps
module tb_panel_switch_scanner;

  localparam int NB  = 32;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sdata;
  logic          sclk;
  logic          sload_n;
  logic [NB-1:0] switches;
  logic          switchesValid;
  logic [NB-1:0] pressed;

  int tests = 0;
  int fails = 0;

  panel_switch_scanner #(
    .NUM_BITS       (NB),
    .CLK_DIV        (8),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sdata         (sdata),
    .sclk          (sclk),
    .sload_n       (sload_n),
    .switches      (switches),
    .switchesValid (switchesValid),
    .pressed       (pressed)
  );

  always #5 clk = ~clk;

  // Shift-register chain: level-sensitive parallel load, shift on sclk rise, QH = MSB.
  logic [NB-1:0] pattern = '0;
  logic [NB-1:0] chain   = '0;
  logic          chain_prev_sclk = 1'b0;
  assign sdata = chain[NB-1];

  always @(negedge clk) begin
    if (!sload_n)                       chain = pattern;
    else if (sclk && !chain_prev_sclk)  chain = chain << 1;
    chain_prev_sclk = sclk;
  end

  // Output monitor: counts valid cycles, captures the published vector, flags stray presses.
  int            vtotal = 0;
  int            stray  = 0;
  logic [NB-1:0] cap_sw = '0;
  logic [NB-1:0] cap_pr = '0;

  always @(negedge clk) begin
    if (switchesValid) begin
      vtotal = vtotal + 1;
      cap_sw = switches;
      cap_pr = pressed;
    end else if (pressed !== '0) begin
      stray = stray + 1;
    end
  end

  // Reference model: the last DEB loaded scans; all equal and new => publish.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_sw      = '0;
  logic          exp_valid = 1'b0;
  logic [NB-1:0] exp_pr    = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_sw      = '0;
    exp_valid = 1'b0;
    exp_pr    = '0;
  endtask

  task automatic model_push(input logic [NB-1:0] pat);
    bit same;
    hist.push_back(pat);
    if (hist.size() > DEB) void'(hist.pop_front());
    exp_valid = 1'b0;
    exp_pr    = '0;
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same && hist[0] != m_sw) begin
        exp_valid = 1'b1;
        exp_pr    = hist[0] & ~m_sw;
        m_sw      = hist[0];
      end
    end
  endtask

  task automatic wait_sload(input logic lvl, input string tag);
    int n = 0;
    while (sload_n !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(sload_n), 64'(lvl));
  endtask

  // One scan: present pat, check what the previous scan published, then let pat load.
  task automatic do_scan(input logic [NB-1:0] pat);
    int base;
    pattern = pat;
    base    = vtotal;
    wait_sload(1'b0, "load_start");
    check("valid_pulses", 64'(vtotal - base), 64'(exp_valid));
    check("switches", 64'(switches), 64'(m_sw));
    if (exp_valid) begin
      check("valid_switches", 64'(cap_sw), 64'(m_sw));
      check("valid_pressed", 64'(cap_pr), 64'(exp_pr));
    end
    wait_sload(1'b1, "load_end");
    model_push(pat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, 64'(sclk), 64'd0);
    check({tag, "_sload_n"}, 64'(sload_n), 64'd1);
    check({tag, "_switches"}, 64'(switches), 64'd0);
    check({tag, "_valid"}, 64'(switchesValid), 64'd0);
    check({tag, "_pressed"}, 64'(pressed), 64'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            lowcnt, highcnt, rises, run, maxrun, in_load, n, r;
    logic          prev;
    logic [NB-1:0] p;

    // Reset and frame timing
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    wait_sload(1'b0, "first_load");
    lowcnt  = 0;
    in_load = 0;
    for (int i = 0; i < 100 && sload_n === 1'b0; i++) begin
      lowcnt++;
      if (sclk) in_load++;
      @(negedge clk);
    end
    highcnt = 0; rises = 0; run = 0; maxrun = 0; prev = sclk;
    for (int i = 0; i < 2000 && sload_n === 1'b1; i++) begin
      if (sclk && !prev) rises++;
      run  = sclk ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      prev = sclk;
      highcnt++;
      @(negedge clk);
    end
    check("load_low_cycles", 64'(lowcnt), 64'd8);
    check("sclk_in_load", 64'(in_load), 64'd0);
    check("sclk_rises", 64'(rises), 64'd32);
    check("sclk_high_half", 64'(maxrun), 64'd8);
    check("scan_period", 64'(lowcnt + highcnt), 64'd529);

    // Static pattern, held past acceptance
    for (int i = 0; i < 6; i++) do_scan(32'hA5C3_0F81);
    // All released, then bit 0 bounces for 10 scans before settling high
    for (int i = 0; i < 5; i++) do_scan(32'h0000_0000);
    for (int i = 0; i < 10; i++) do_scan((i % 2 == 0) ? 32'h0000_0001 : 32'h0000_0000);
    for (int i = 0; i < 5; i++) do_scan(32'h0000_0001);
    // Release of bit 1 from 0x3
    for (int i = 0; i < 5; i++) do_scan(32'h0000_0003);
    for (int i = 0; i < 5; i++) do_scan(32'h0000_0001);

    // Random segments: fresh vectors and single-bit flips with random hold lengths
    p = 32'h0000_0001;
    for (int s = 0; s < 6; s++) begin
      if (s % 2 == 0) p = $urandom;
      else            p = p ^ (32'h1 << $urandom_range(0, NB - 1));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) do_scan(p);
    end
    for (int i = 0; i < DEB; i++) do_scan(p);

    // Reset after 10 shift clocks: partial scan is discarded
    p = $urandom;
    do_scan(p);
    r = 0; n = 0; prev = sclk;
    while (r < 10 && n < 2000) begin
      @(negedge clk);
      if (sclk && !prev) r++;
      prev = sclk;
      n++;
    end
    check("rises_before_reset", 64'(r), 64'd10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p = $urandom | 32'h8000_0001;
    for (int i = 0; i < DEB + 1; i++) do_scan(p);
    check("post_reset_switches", 64'(switches), 64'(p));

    check("stray_pressed", 64'(stray), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
